// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 receive path:
//   ps2_state_t         - deframing FSM states
//   PS2_FRAME_BITS      - bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_DATA_BITS       - data bits carried by one frame
//   DEFAULT_FILTER_LEN  - default clock-filter length in clk cycles
//   DEFAULT_TIMEOUT     - default in-frame watchdog limit in clk cycles
//   odd_parity_ok()     - 1 when byte plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int PS2_FRAME_BITS     = 11;
  localparam int PS2_DATA_BITS      = PS2_FRAME_BITS - 3;
  localparam int DEFAULT_FILTER_LEN = 4;
  localparam int DEFAULT_TIMEOUT    = 5000;

  function automatic logic odd_parity_ok(input logic [7:0] byte_val, input logic par);
    return ^{byte_val, par};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo
// Small synchronous FIFO with show-ahead output.
//   clk, rst  - clock and synchronous active-high reset
//   push, din - write request and write data (ignored while full unless popping)
//   pop       - read request (ignored while empty)
//   dout      - head entry, forced to 0 while empty
//   full      - no free entry
//   empty     - no stored entry
module ps2_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// PS/2 keyboard receiver: synchronises and deglitches the device clock,
// deframes 11-bit frames and queues good scan-code bytes for the IO bus.
//   clk, rst  - system clock, synchronous active-high reset
//   ps2_clk   - raw PS/2 clock pin (asynchronous)
//   ps2_data  - raw PS/2 data pin (asynchronous)
//   rd        - one-cycle pop strobe from the IO bus
//   clr_err   - clears frame_err and overflow (a new error in the same cycle wins)
//   data      - FIFO head byte, valid while ready
//   ready     - FIFO non-empty
//   frame_err - sticky: a frame was rejected (parity, stop bit or timeout)
//   overflow  - sticky: a good byte was dropped because the FIFO was full
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(PS2_DATA_BITS - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          fclk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [WW-1:0] wdog;
  logic          stop_ok, stop_bad, timeout_hit;
  logic          fifo_full, fifo_empty, fifo_drop;

  // Idle-high synchronisers so reset does not look like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock only follows after FILTER_LEN consecutive differing
  // samples; strobe is registered together with the falling fclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 != fclk) begin
        if (filt_cnt == FILT_LAST) begin
          fclk     <= clk_s2;
          filt_cnt <= '0;
          strobe   <= ~clk_s2;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Push is combinational so the byte is written at the edge ending the STOP strobe.
  assign stop_ok     = strobe && (state == ST_STOP) && dat_s2 && odd_parity_ok(shreg, par_bit);
  assign stop_bad    = strobe && (state == ST_STOP) && !stop_ok;
  assign timeout_hit = (state != ST_IDLE) && !strobe && (wdog == WDOG_LAST);
  assign fifo_drop   = stop_ok && fifo_full && !(rd && !fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      wdog    <= '0;
    end else begin
      if (state == ST_IDLE || strobe) wdog <= '0;
      else                            wdog <= wdog + WW'(1);

      if (timeout_hit) begin
        state <= ST_IDLE;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!dat_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s2;
            state   <= ST_STOP;
          end
          ST_STOP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (stop_bad || timeout_hit) frame_err <= 1'b1;
      else if (clr_err)            frame_err <= 1'b0;
      if (fifo_drop)               overflow  <= 1'b1;
      else if (clr_err)            overflow  <= 1'b0;
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stop_ok),
    .din   (shreg),
    .pop   (rd),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_empty;

endmodule
